// File: rtl/vadd_stream_driver_if.sv
// Host request/response and kernel in/out stream bundle for vadd_stream_driver.
// master = driver side, slave = host/kernel side.
interface vadd_stream_driver_if #(
   parameter int unsigned C_DATA_WIDTH = 512
);
   logic                    req_valid;
   logic                    req_ready;
   logic [C_DATA_WIDTH-1:0] req_data;
   logic                    resp_valid;
   logic                    resp_ready;
   logic [C_DATA_WIDTH-1:0] resp_data;
   logic                    resp_last;
   logic                    k_in_ready;
   logic                    k_in_avail;
   logic [C_DATA_WIDTH-1:0] k_in_data;
   logic                    k_out_ready;
   logic                    k_out_avail;
   logic [C_DATA_WIDTH-1:0] k_out_data;

   modport master (
      input  req_valid, req_data, resp_ready, k_in_ready, k_out_avail, k_out_data,
      output req_ready, resp_valid, resp_data, resp_last, k_in_avail, k_in_data, k_out_ready
   );

   modport slave (
      output req_valid, req_data, resp_ready, k_in_ready, k_out_avail, k_out_data,
      input  req_ready, resp_valid, resp_data, resp_last, k_in_avail, k_in_data, k_out_ready
   );
endinterface

// File: rtl/vadd_stream_driver.sv
// Host-side driver for the vadd kernel stream: one request in, N response chunks out via FWFT FIFO.
// Optional response watchdog enabled by defining STREAM_DRV_TIMEOUT_EN.
module vadd_stream_driver #(
   parameter int unsigned C_DATA_WIDTH   = 512,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   vadd_stream_driver_if.master bus,
   output logic                 done,
   output logic [15:0]          req_cnt,
   output logic [15:0]          resp_cnt,
   output logic                 seq_err,
   output logic                 timeout_err
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   if ((C_DATA_WIDTH % 32) != 0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       TIMEOUT_CYCLES == 0) begin : g_param_chk
      $error("vadd_stream_driver: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, SEND, COLLECT} state_t;

   state_t                  state, state_nxt;
   logic [7:0]              rem, rem_nxt;
   logic                    done_nxt;
   logic [C_DATA_WIDTH-1:0] req_lat;
   logic                    req_take, kin_take, push, pop, wd_trip;

   logic [C_DATA_WIDTH:0]   mem [FIFO_DEPTH];
   logic [AW:0]             wp, rp;
   logic                    full, empty;

   assign empty          = (wp == rp);
   assign full           = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop            = !empty && bus.resp_ready;
   assign bus.resp_valid = !empty;
   assign bus.resp_data  = empty ? '0 : mem[rp[AW-1:0]][C_DATA_WIDTH-1:0];
   assign bus.resp_last  = !empty && mem[rp[AW-1:0]][C_DATA_WIDTH];
   assign bus.k_in_data  = req_lat;

   always_comb begin
      state_nxt       = state;
      rem_nxt         = rem;
      done_nxt        = 1'b0;
      req_take        = 1'b0;
      kin_take        = 1'b0;
      push            = 1'b0;
      bus.req_ready   = 1'b0;
      bus.k_in_avail  = 1'b0;
      bus.k_out_ready = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = reset_n;
            if (bus.req_valid) begin
               req_take  = 1'b1;
               rem_nxt   = bus.req_data[7:0];
               state_nxt = SEND;
            end
         end
         SEND: begin
            bus.k_in_avail  = !full;
            // First chunk is only taken alongside the k_in transfer, so a stray out_avail is never consumed here.
            bus.k_out_ready = !full && bus.k_in_ready && (rem != 8'd0);
            if (!full && bus.k_in_ready) begin
               kin_take = 1'b1;
               if (rem == 8'd0) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else if (bus.k_out_avail) begin
                  push    = 1'b1;
                  rem_nxt = rem - 8'd1;
                  if (rem == 8'd1) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = COLLECT;
                  end
               end else begin
                  state_nxt = COLLECT;
               end
            end
         end
         COLLECT: begin
            bus.k_out_ready = !full;
            if (!full && bus.k_out_avail) begin
               push    = 1'b1;
               rem_nxt = rem - 8'd1;
               if (rem == 8'd1) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end else if (wd_trip) begin
               state_nxt = IDLE;
               rem_nxt   = 8'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         rem      <= '0;
         done     <= 1'b0;
         req_lat  <= '0;
         req_cnt  <= '0;
         resp_cnt <= '0;
         seq_err  <= 1'b0;
         wp       <= '0;
         rp       <= '0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
         done  <= done_nxt;
         if (req_take) req_lat <= bus.req_data;
         if (kin_take) req_cnt <= req_cnt + 16'd1;
         if (pop) begin
            resp_cnt <= resp_cnt + 16'd1;
            rp       <= rp + PTR_ONE;
         end
         if (push) begin
            wp <= wp + PTR_ONE;
            // Chunk low byte counts down to 0; only the low byte is checked.
            if (bus.k_out_data[7:0] != rem - 8'd1) seq_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp[AW-1:0]] <= {(rem == 8'd1), bus.k_out_data};
   end

`ifdef STREAM_DRV_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;

   // In COLLECT k_out_ready is exactly !full.
   assign wd_trip = (state == COLLECT) && !full && !bus.k_out_avail &&
                    (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state != COLLECT || wd_trip || (!full && bus.k_out_avail)) begin
            wd_cnt <= '0;
         end else if (!full) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end
         if (wd_trip) timeout_err <= 1'b1;
      end
   end
`else
   assign wd_trip     = 1'b0;
   assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_vadd_stream_driver.sv
// Self-checking bench for vadd_stream_driver: table of request vectors plus reset/drain/timeout sequences.
module tb_vadd_stream_driver;
   localparam int unsigned W  = 512;
   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        done;
   logic [15:0] req_cnt, resp_cnt;
   logic        seq_err, timeout_err;

   always #5 clk = ~clk;

   vadd_stream_driver_if #(.C_DATA_WIDTH(W)) bus ();

   vadd_stream_driver #(
      .C_DATA_WIDTH(W),
      .FIFO_DEPTH(4),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus),
      .done(done),
      .req_cnt(req_cnt),
      .resp_cnt(resp_cnt),
      .seq_err(seq_err),
      .timeout_err(timeout_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Kernel model + host sink, all driven on the falling edge.
   logic [W-1:0]  kq[$];
   logic [16:0]   rx[$];
   logic [W-1:0]  kchunk;
   int            env_n;
   int            kern_corrupt = -1;
   int            kern_stop = 1000;
   logic          host_ready = 1'b1;
   int            done_cnt = 0;

   initial begin
      bus.k_in_ready  = 1'b1;
      bus.k_out_avail = 1'b0;
      bus.k_out_data  = '0;
      bus.resp_ready  = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            kq.delete();
         end else if (bus.k_in_avail && bus.k_in_ready) begin
            env_n = int'(bus.k_in_data[7:0]);
            for (int i = 0; i < env_n && i < kern_stop; i++) begin
               kchunk        = '0;
               kchunk[7:0]   = (i == kern_corrupt) ? 8'h05 : 8'(env_n - 1 - i);
               kchunk[39:32] = 8'(i);
               kchunk[95:64] = 32'hDEAD_0000 + 32'(i);
               kq.push_back(kchunk);
            end
         end
         bus.k_out_avail = (kq.size() > 0);
         bus.k_out_data  = (kq.size() > 0) ? kq[0] : '0;
         bus.resp_ready  = host_ready;
         #1;
         if (reset_n) begin
            if (bus.k_out_avail && bus.k_out_ready) void'(kq.pop_front());
            if (bus.resp_valid && bus.resp_ready)
               rx.push_back({bus.resp_last, bus.resp_data[39:32], bus.resp_data[7:0]});
            if (done) done_cnt++;
         end
      end
   end

   task automatic send_req(input logic [7:0] n);
      int t;
      @(negedge clk);
      bus.req_valid     = 1'b1;
      bus.req_data      = {16{32'h0000_0100}};
      bus.req_data[7:0] = n;
      #1;
      t = 0;
      while (!bus.req_ready && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("req accepted", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int exp_beats);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         #2;
         t++;
      end while (!(bus.req_ready && !bus.resp_valid && rx.size() >= exp_beats) && t < 300);
      if (t >= 300) check("wait idle bound", 64'd0, 64'd1);
      repeat (2) @(negedge clk);
      #2;
   endtask

   typedef struct {
      logic [7:0] n;
      int         corrupt;
      int         hold;
      logic       exp_seq;
   } vec_t;

   vec_t vecs[5];
   int   exp_req, exp_resp;
   logic [7:0] exp_lo;

   initial begin
      vecs[0] = '{n: 8'd3, corrupt: -1, hold: 0,  exp_seq: 1'b0};
      vecs[1] = '{n: 8'd8, corrupt: -1, hold: 20, exp_seq: 1'b0};
      vecs[2] = '{n: 8'd0, corrupt: -1, hold: 0,  exp_seq: 1'b0};
      vecs[3] = '{n: 8'd4, corrupt: 1,  hold: 0,  exp_seq: 1'b1};
      vecs[4] = '{n: 8'd1, corrupt: -1, hold: 0,  exp_seq: 1'b1};

      bus.req_valid = 1'b0;
      bus.req_data  = '0;
      #12;
      check("rst req_ready",   64'(bus.req_ready),   64'd0);
      check("rst resp_valid",  64'(bus.resp_valid),  64'd0);
      check("rst k_in_avail",  64'(bus.k_in_avail),  64'd0);
      check("rst k_out_ready", 64'(bus.k_out_ready), 64'd0);
      check("rst done",        64'(done),            64'd0);
      check("rst req_cnt",     64'(req_cnt),         64'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #2;
      check("post-rst req_ready", 64'(bus.req_ready), 64'd1);

      exp_req  = 0;
      exp_resp = 0;
      for (int v = 0; v < 5; v++) begin
         rx.delete();
         done_cnt     = 0;
         kern_corrupt = vecs[v].corrupt;
         host_ready   = (vecs[v].hold == 0);
         send_req(vecs[v].n);
         if (vecs[v].hold > 0) begin
            repeat (vecs[v].hold) @(negedge clk);
            #2;
            check($sformatf("v%0d stall k_out_ready", v), 64'(bus.k_out_ready), 64'd0);
            check($sformatf("v%0d stall resp_valid", v),  64'(bus.resp_valid),  64'd1);
            check($sformatf("v%0d stall beats", v),       64'(rx.size()),        64'd0);
            host_ready = 1'b1;
         end
         wait_idle(int'(vecs[v].n));
         exp_req++;
         exp_resp += int'(vecs[v].n);
         check($sformatf("v%0d beats", v), 64'(rx.size()), 64'(vecs[v].n));
         for (int i = 0; i < rx.size(); i++) begin
            exp_lo = (i == vecs[v].corrupt) ? 8'h05 : 8'(int'(vecs[v].n) - 1 - i);
            check($sformatf("v%0d beat%0d lo", v, i),   64'(rx[i][7:0]),  64'(exp_lo));
            check($sformatf("v%0d beat%0d tag", v, i),  64'(rx[i][15:8]), 64'(i));
            check($sformatf("v%0d beat%0d last", v, i), 64'(rx[i][16]),
                  64'(i == int'(vecs[v].n) - 1));
         end
         check($sformatf("v%0d done pulses", v), 64'(done_cnt), 64'd1);
         check($sformatf("v%0d req_cnt", v),     64'(req_cnt),  64'(exp_req));
         check($sformatf("v%0d resp_cnt", v),    64'(resp_cnt), 64'(exp_resp));
         check($sformatf("v%0d seq_err", v),     64'(seq_err),  64'(vecs[v].exp_seq));
      end
      kern_corrupt = -1;

      // Second request accepted while the first one's chunks are still queued.
      rx.delete();
      done_cnt   = 0;
      host_ready = 1'b0;
      send_req(8'd2);
      send_req(8'd1);
      repeat (3) @(negedge clk);
      host_ready = 1'b1;
      wait_idle(3);
      check("b2b beats",  64'(rx.size()), 64'd3);
      check("b2b beat0",  64'(rx[0]),     64'h0_0001);
      check("b2b beat1",  64'(rx[1]),     64'h1_0100);
      check("b2b beat2",  64'(rx[2]),     64'h1_0000);
      check("b2b done",   64'(done_cnt),  64'd2);
      check("b2b req_cnt", 64'(req_cnt),  64'(exp_req + 2));

      // Reset in the middle of COLLECT after two chunks.
      rx.delete();
      kern_stop = 2;
      send_req(8'd6);
      for (int t = 0; t < 50 && rx.size() < 2; t++) @(negedge clk);
      check("mid beats before rst", 64'(rx.size()), 64'd2);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid-rst req_ready",   64'(bus.req_ready),   64'd0);
      check("mid-rst resp_valid",  64'(bus.resp_valid),  64'd0);
      check("mid-rst resp_data",   64'(|bus.resp_data),  64'd0);
      check("mid-rst resp_last",   64'(bus.resp_last),   64'd0);
      check("mid-rst k_in_avail",  64'(bus.k_in_avail),  64'd0);
      check("mid-rst k_in_data",   64'(|bus.k_in_data),  64'd0);
      check("mid-rst k_out_ready", 64'(bus.k_out_ready), 64'd0);
      check("mid-rst done",        64'(done),            64'd0);
      check("mid-rst req_cnt",     64'(req_cnt),         64'd0);
      check("mid-rst resp_cnt",    64'(resp_cnt),        64'd0);
      check("mid-rst seq_err",     64'(seq_err),         64'd0);
      check("mid-rst timeout_err", 64'(timeout_err),     64'd0);
      repeat (2) @(negedge clk);
      #3;
      reset_n   = 1'b1;
      kern_stop = 1000;
      @(negedge clk);
      #2;
      check("rel req_ready",  64'(bus.req_ready),  64'd1);
      check("rel resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rel resp_cnt",   64'(resp_cnt),       64'd0);
      rx.delete();
      done_cnt = 0;
      send_req(8'd2);
      wait_idle(2);
      check("after-rst beats",    64'(rx.size()), 64'd2);
      check("after-rst req_cnt",  64'(req_cnt),   64'd1);
      check("after-rst resp_cnt", 64'(resp_cnt),  64'd2);
      check("after-rst done",     64'(done_cnt),  64'd1);

`ifdef STREAM_DRV_TIMEOUT_EN
      rx.delete();
      done_cnt  = 0;
      kern_stop = 1;
      send_req(8'd3);
      repeat (10) @(negedge clk);
      #2;
      check("to early", 64'(timeout_err), 64'd0);
      for (int t = 0; t < 30 && !timeout_err; t++) @(negedge clk);
      #2;
      check("to flag", 64'(timeout_err), 64'd1);
      wait_idle(1);
      check("to beats", 64'(rx.size()), 64'd1);
      check("to last",  64'(rx[0][16]), 64'd0);
      check("to done",  64'(done_cnt),  64'd0);
      kern_stop = 1000;
      rx.delete();
      send_req(8'd1);
      wait_idle(1);
      check("to next beats",  64'(rx.size()),     64'd1);
      check("to sticky",      64'(timeout_err),   64'd1);
`else
      check("no-watchdog timeout_err", 64'(timeout_err), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global time limit: got running expected finished");
      $fatal(1, "time limit");
   end
endmodule
